// File: rtl/out_port_fifo.sv
// Buffered CPU output port: DEPTH-entry FIFO drained by a device over valid/ready.
// Optional interrupt (ien/irq) is built only when OUTP_IRQ_EN is defined.
module out_port_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] data_in,
  output logic             fgo,
  output logic [WIDTH-1:0] dev_data,
  output logic             dev_valid,
  input  logic             dev_ready,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             clr_ovf
`ifdef OUTP_IRQ_EN
  ,
  input  logic             ien,
  output logic             irq
`endif
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;
  logic [AW:0]      count_next;

  // Handshake: a word transfers on any rising edge where dev_valid && dev_ready.
  // dev_valid is a pure function of registered occupancy (never of dev_ready),
  // and dev_data holds the head word steady until that transfer edge.
  assign pop  = dev_valid && dev_ready;
  assign push = ld && ((count != FULL) || pop);
  assign drop = ld && !push;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + (AW+1)'(1);
    else if (pop && !push)
      count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign dev_valid = (count != '0);
  assign fgo       = (count != FULL);
  assign dev_data  = mem[rd_ptr];

`ifdef OUTP_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irq <= 1'b0;
    else
      irq <= ien && (count_next != FULL);
  end
`endif

endmodule

// File: doc/out_port_fifo.md
# out_port_fifo

Parametrised output port for the accumulator CPU. The CPU's OUT instruction pushes words through `ld`/`data_in` into a DEPTH-entry FIFO, and an external device such as a UART transmitter drains it over a valid/ready handshake. `fgo` tells the CPU the port can accept another word. The block replaces the single-register output stage: it adds buffering, backpressure, overflow detection and an optional interrupt.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 4: number of FIFO entries; must be a power of two, at least 2.
- `AW`, local, `$clog2(DEPTH)`: pointer width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ld`  in  1  CPU write strobe; pushes `data_in` on the next edge.
- `data_in`  in  WIDTH  word to output.
- `fgo`  out  1  output flag; 1 when the FIFO is not full.
- `dev_data`  out  WIDTH  head-of-FIFO word presented to the device.
- `dev_valid`  out  1  FIFO not empty.
- `dev_ready`  in  1  device accepts `dev_data` this cycle.
- `count`  out  AW+1  number of occupied entries, 0..DEPTH.
- `overflow`  out  1  sticky; set when a push is dropped.
- `clr_ovf`  in  1  clears `overflow`.
- `ien`  in  1  interrupt enable; present only with `OUTP_IRQ_EN`.
- `irq`  out  1  interrupt request; present only with `OUTP_IRQ_EN`.

## Operation
- **Storage.** Circular buffer `mem[DEPTH]` with AW-bit `wr_ptr` and `rd_ptr`, plus an AW+1-bit `count` register.
  - Pointers wrap naturally from DEPTH-1 to 0.
- **Push.** `push = ld && (count < DEPTH || pop)`.
  - On push: `mem[wr_ptr] <= data_in` and `wr_ptr` increments.
- **Pop.** `pop = dev_valid && dev_ready`. On pop, `rd_ptr` increments.
- **Count update.**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
- **Full with simultaneous pop.** `ld` while full and `dev_ready` high is accepted; the slot freed by the pop is reused.
- **Drop.** `ld` while full with no pop in the same cycle:
  - the word is dropped and no state changes except `overflow <= 1`;
  - `wr_ptr` and `count` are untouched.
- **Overflow clear.**
  - `clr_ovf` clears `overflow`.
  - If a drop occurs in the same cycle, the set wins.
- **Output decodes** (combinational from registered state):
  - `dev_valid = (count != 0)`
  - `fgo = (count != DEPTH)`
  - `dev_data = mem[rd_ptr]`
- **Contents when empty.** `dev_data` shows stale memory contents while `dev_valid` is 0; the device must ignore it.
- **`ld` with all-zero data.** A zero word is a legal data word and is pushed like any other; there is no data-dependent flag behaviour.
- **Reset.** Asynchronous assertion of `rst_n` = 0 clears everything, including mid-transfer:
  - `wr_ptr`, `rd_ptr`, `count` and `overflow` go to 0;
  - all `mem` entries go to 0.
  - Resulting outputs: `fgo`=1, `dev_valid`=0, `dev_data`=0, `count`=0, `overflow`=0, `irq`=0.
  - Any word in flight is lost.

## Timing
- **Push latency.** A word written with `ld` at edge N is visible at `dev_data` with `dev_valid`=1 after edge N.
  - This gives a 1-cycle push-to-valid latency.
  - There is no combinational path from `data_in` to `dev_data`.
- **Handshake.**
  - `dev_valid` never depends on `dev_ready`.
  - Once `dev_valid` is asserted, `dev_data` stays stable until the pop edge.
- **`fgo` timing.**
  - `fgo` falls the cycle after the push that fills the FIFO.
  - `fgo` rises the cycle after the pop that frees an entry.
- **Throughput.** One push and one pop per cycle are sustainable at any occupancy.
- **Reset release.** Deassertion is synchronised by the top level; the block's first active edge after release may accept `ld`.

## Configuration
- Macro: `OUTP_IRQ_EN`.
- **Defined:**
  - `ien` and `irq` ports exist.
  - `irq` is a register updated each edge to `ien && fgo_next`, where `fgo_next` is the post-update value of `fgo`; its reset value is 0.
  - `irq` therefore asserts one cycle after space becomes available while enabled.
- **Undefined:**
  - Ports `ien` and `irq` are absent.
  - No interrupt logic is synthesised; the CPU polls `fgo`.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-stream holding 3 entries → `count`=0, `fgo`=1, `dev_valid`=0, `dev_data`=0 immediately, without waiting for a clock edge.
- **Fill and drop** (WIDTH=8, DEPTH=4, `dev_ready`=0). Push 0x11, 0x22, 0x33, 0x44 → `fgo`=0 and `count`=4. Push 0x55 → `overflow`=1 and `count`=4. Drain → 0x11, 0x22, 0x33, 0x44 in order, and 0x55 never appears.
- **Full with simultaneous push/pop.** Full FIFO, `ld` with 0x66 and `dev_ready`=1 in the same cycle → 0x11 popped, `count` stays 4, `overflow` unchanged, 0x66 emerges last.
- **Wrap-around.** 10 push/pop pairs with random back-pressure on `dev_ready` → output sequence equals input sequence, and `count` never exceeds 4.
- **Zero data and latency.** Push 0x00 into an empty FIFO → `dev_valid`=1 one cycle later with `dev_data`=0x00. Then `clr_ovf` coinciding with a drop → `overflow` stays 1.
- **Interrupt** (`OUTP_IRQ_EN`, `ien`=1). Fill the FIFO → `irq`=0 the cycle after `fgo` falls. Pop one entry → `irq`=1 the cycle after the pop. Set `ien`=0 → `irq`=0 next cycle.
